// File: rtl/stack_isa_pkg.sv
// stack_isa_pkg: opcodes, fault codes and sequencer states for the 8-bit stack processor
package stack_isa_pkg;
   localparam logic [7:0] OP_PUSHC  = 8'h00;
   localparam logic [7:0] OP_PUSH   = 8'h01;
   localparam logic [7:0] OP_POP    = 8'h02;
   localparam logic [7:0] OP_ADD    = 8'h06;
   localparam logic [7:0] OP_SUB    = 8'h07;
   localparam logic [7:0] OP_FINISH = 8'h0F;
   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_OVF  = 2'd1;
   localparam logic [1:0] ERR_UNF  = 2'd2;
   localparam logic [1:0] ERR_ILL  = 2'd3;
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_OPND, S_RD_SRC, S_RD_A, S_RD_B, S_WRITE, S_HALT
   } state_t;
endpackage

// File: rtl/stack_alu.sv
// stack_alu: 8-bit wrapping add or subtract, subtract selected by opcode bit 0
module stack_alu (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       sub,
   output logic [7:0] y
);
   assign y = sub ? a - b : a + b;
endmodule

// File: rtl/stack_sequencer.sv
// stack_sequencer: fetch/decode/execute control and sole memory master of the stack processor
module stack_sequencer
   import stack_isa_pkg::*;
#(
   parameter logic [7:0] STACK_TOP   = 8'hEF,
   parameter logic [7:0] STACK_LIMIT = 8'h80
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [7:0] mem_addr,
   output logic       mem_readwriteN,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] err_code,
   output logic [7:0] pc,
   output logic [7:0] sp
);
   state_t     state;
   logic [7:0] op, opnd, tos, alu_y, sp1, sp2, pc1, pc_next, sp_next;
   logic       dec_push, dec_pop, dec_arith, dec_fin;
   logic [1:0] fault;

   stack_alu alu (.a(tos), .b(mem_rdata), .sub(op[0]), .y(alu_y));

   assign sp1     = sp + 8'd1;
   assign sp2     = sp + 8'd2;
   assign pc1     = pc + 8'd1;
   assign pc_next = pc + ((op == OP_ADD || op == OP_SUB) ? 8'd1 : 8'd2);
   assign sp_next = (op == OP_PUSHC || op == OP_PUSH) ? sp - 8'd1 : sp1;

   // Decode the opcode arriving on the fetch read and classify faults before any access
   always_comb begin
      dec_push  = mem_rdata == OP_PUSHC || mem_rdata == OP_PUSH;
      dec_pop   = mem_rdata == OP_POP;
      dec_arith = mem_rdata == OP_ADD || mem_rdata == OP_SUB;
      dec_fin   = mem_rdata == OP_FINISH;
      fault     = !(dec_push || dec_pop || dec_arith || dec_fin) ? ERR_ILL :
                  (dec_push && sp < STACK_LIMIT) ? ERR_OVF :
                  ((dec_pop && sp == STACK_TOP) || (dec_arith && sp >= STACK_TOP - 8'd1)) ? ERR_UNF :
                  ERR_NONE;
   end

   // Sequencer: each state presents the memory access of the next state on its exit edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         pc             <= 8'd0;
         sp             <= STACK_TOP;
         mem_addr       <= 8'd0;
         mem_readwriteN <= 1'b1;
         mem_wdata      <= 8'd0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         err_code       <= ERR_NONE;
         op             <= 8'd0;
         opnd           <= 8'd0;
         tos            <= 8'd0;
      end else begin
         case (state)
            S_IDLE, S_HALT: if (start) begin
               state    <= S_FETCH;
               pc       <= 8'd0;
               sp       <= STACK_TOP;
               mem_addr <= 8'd0;
               busy     <= 1'b1;
               done     <= 1'b0;
               error    <= 1'b0;
               err_code <= ERR_NONE;
            end
            S_FETCH: begin
               op <= mem_rdata;
               if (fault != ERR_NONE) begin
                  state    <= S_HALT;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  error    <= 1'b1;
                  err_code <= fault;
               end else if (dec_fin) begin
                  state <= S_HALT;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (dec_arith) begin
                  state    <= S_RD_A;
                  mem_addr <= sp1;
               end else begin
                  state    <= S_OPND;
                  mem_addr <= pc1;
               end
            end
            S_OPND: begin
               opnd <= mem_rdata;
               if (op == OP_PUSHC) begin
                  state          <= S_WRITE;
                  mem_addr       <= sp;
                  mem_wdata      <= mem_rdata;
                  mem_readwriteN <= 1'b0;
               end else if (op == OP_PUSH) begin
                  state    <= S_RD_SRC;
                  mem_addr <= mem_rdata;
               end else begin
                  state    <= S_RD_A;
                  mem_addr <= sp1;
               end
            end
            S_RD_SRC: begin
               state          <= S_WRITE;
               mem_addr       <= sp;
               mem_wdata      <= mem_rdata;
               mem_readwriteN <= 1'b0;
            end
            S_RD_A: if (op == OP_POP) begin
               state          <= S_WRITE;
               mem_addr       <= opnd;
               mem_wdata      <= mem_rdata;
               mem_readwriteN <= 1'b0;
            end else begin
               tos      <= mem_rdata;
               state    <= S_RD_B;
               mem_addr <= sp2;
            end
            S_RD_B: begin
               state          <= S_WRITE;
               mem_addr       <= sp2;
               mem_wdata      <= alu_y;
               mem_readwriteN <= 1'b0;
            end
            S_WRITE: begin
               state          <= S_FETCH;
               mem_readwriteN <= 1'b1;
               pc             <= pc_next;
               sp             <= sp_next;
               mem_addr       <= pc_next;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: instruction-level model predicts every cycle of each program run
module tb_stack_sequencer;
   localparam logic [7:0] TOP = 8'hEF;
   localparam logic [7:0] LIM = 8'hEE;

   logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [7:0] mem_addr, mem_wdata, mem_rdata = 8'd0, pc, sp;
   logic       mem_readwriteN, busy, done, error;
   logic [1:0] err_code;
   logic [7:0] ram [256];
   logic [7:0] prog [$];

   typedef struct {
      logic [7:0] pc, sp;
      logic       wr;
      logic [7:0] addr, data;
   } cyc_t;
   cyc_t       tr [$];
   logic [7:0] e_pc, e_sp;
   logic [1:0] e_err;
   int         npass = 0, ntot = 0;

   stack_sequencer #(.STACK_TOP(TOP), .STACK_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr),
      .mem_readwriteN(mem_readwriteN), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .error(error), .err_code(err_code), .pc(pc), .sp(sp)
   );

   always #5 clk = ~clk;

   // Memory samples on negedge, registered read, writes at F9..FF ignored
   always @(negedge clk) begin
      mem_rdata = ram[mem_addr];
      if (!mem_readwriteN && mem_addr < 8'hF9) ram[mem_addr] = mem_wdata;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
      ntot++;
      if (a === e) npass++;
      else $display("FAIL %s: got %0h want %0h", n, a, e);
   endtask

   task automatic load();
      for (int i = 0; i < 256; i++) ram[i] = 8'd0;
      foreach (prog[i]) ram[i] = prog[i];
   endtask

   task automatic emit(input int nrd, input logic [7:0] p, input logic [7:0] s,
                       input logic w, input logic [7:0] a, input logic [7:0] d);
      cyc_t c;
      c.pc = p; c.sp = s; c.wr = 1'b0; c.addr = 8'd0; c.data = 8'd0;
      for (int i = 0; i < nrd; i++) tr.push_back(c);
      c.wr = 1'b1; c.addr = a; c.data = d;
      if (w) tr.push_back(c);
   endtask

   // Interpret the program instruction by instruction; each instruction costs a fixed cycle count
   task automatic build();
      logic [7:0] m [256];
      logic [7:0] p, s, op, o, v, x, y, n1;
      for (int i = 0; i < 256; i++) m[i] = ram[i];
      p = 8'd0; s = TOP; e_err = 2'd0; tr.delete();
      for (int g = 0; g < 100; g++) begin
         n1 = p + 8'd1;
         op = m[p]; o = m[n1];
         x = s + 8'd1; y = s + 8'd2;
         if (op == 8'h00 || op == 8'h01) begin
            if (s < LIM) begin emit(1, p, s, 0, 0, 0); e_err = 2'd1; break; end
            v = (op == 8'h00) ? o : m[o];
            emit(op == 8'h00 ? 2 : 3, p, s, 1, s, v);
            m[s] = v; s = s - 8'd1; p = p + 8'd2;
         end else if (op == 8'h02) begin
            if (s == TOP) begin emit(1, p, s, 0, 0, 0); e_err = 2'd2; break; end
            v = m[x];
            emit(3, p, s, 1, o, v);
            if (o < 8'hF9) m[o] = v;
            s = x; p = p + 8'd2;
         end else if (op == 8'h06 || op == 8'h07) begin
            if (s >= TOP - 8'd1) begin emit(1, p, s, 0, 0, 0); e_err = 2'd2; break; end
            v = (op == 8'h06) ? m[y] + m[x] : m[x] - m[y];
            emit(3, p, s, 1, y, v);
            if (y < 8'hF9) m[y] = v;
            s = x; p = p + 8'd1;
         end else if (op == 8'h0F) begin
            emit(1, p, s, 0, 0, 0); break;
         end else begin
            emit(1, p, s, 0, 0, 0); e_err = 2'd3; break;
         end
      end
      e_pc = p; e_sp = s;
   endtask

   task automatic run(input string n);
      build();
      @(negedge clk); start = 1'b1;
      foreach (tr[i]) begin
         @(posedge clk); #1; start = 1'b0;
         chk({n, ".pc"}, pc, tr[i].pc);
         chk({n, ".sp"}, sp, tr[i].sp);
         chk({n, ".busy"}, 8'(busy), 8'd1);
         chk({n, ".done_low"}, 8'(done), 8'd0);
         chk({n, ".rwN"}, 8'(mem_readwriteN), 8'(!tr[i].wr));
         if (tr[i].wr) begin
            chk({n, ".waddr"}, mem_addr, tr[i].addr);
            chk({n, ".wdata"}, mem_wdata, tr[i].data);
         end
      end
      @(posedge clk); #1; start = 1'b0;
      chk({n, ".done"}, 8'(done), 8'd1);
      chk({n, ".busy_end"}, 8'(busy), 8'd0);
      chk({n, ".error"}, 8'(error), 8'(e_err != 2'd0));
      chk({n, ".err_code"}, 8'(err_code), 8'(e_err));
      chk({n, ".pc_end"}, pc, e_pc);
      chk({n, ".sp_end"}, sp, e_sp);
      chk({n, ".rwN_end"}, 8'(mem_readwriteN), 8'd1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 8'd0;
      #12; @(negedge clk); reset = 1'b0; #1;
      chk("rst.pc", pc, 8'd0);
      chk("rst.sp", sp, TOP);
      chk("rst.addr", mem_addr, 8'd0);
      chk("rst.rwN", 8'(mem_readwriteN), 8'd1);
      chk("rst.wdata", mem_wdata, 8'd0);
      chk("rst.flags", {4'd0, busy, done, error, 1'b0}, 8'd0);
      chk("rst.err_code", 8'(err_code), 8'd0);

      prog = '{8'h00, 8'h0C, 8'h00, 8'h17, 8'h06, 8'h02, 8'hF0, 8'h0F};
      load(); run("add");
      chk("add.cycles", 8'(tr.size() + 1), 8'd16);
      chk("add.mem_f0", ram[8'hF0], 8'h23);
      chk("add.sp_lit", sp, 8'hEF);

      prog = '{8'h00, 8'h05, 8'h00, 8'h14, 8'h07, 8'h0F};
      load(); run("sub");
      chk("sub.mem_ef", ram[8'hEF], 8'h0F);
      chk("sub.sp_lit", sp, 8'hEE);

      prog = '{8'h00, 8'hC8, 8'h00, 8'h64, 8'h06, 8'h0F};
      load(); run("wrap");
      chk("wrap.tos", ram[8'hEF], 8'h2C);

      prog = '{8'h06};
      load(); run("unf");
      chk("unf.code_lit", 8'(err_code), 8'd2);
      chk("unf.pc_lit", pc, 8'd0);
      chk("unf.sp_lit", sp, 8'hEF);

      prog = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h05};
      load(); run("ill");
      chk("ill.code_lit", 8'(err_code), 8'd3);
      chk("ill.pc_lit", pc, 8'd4);

      prog = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
      load(); run("ovf");
      chk("ovf.code_lit", 8'(err_code), 8'd1);
      chk("ovf.pc_lit", pc, 8'd4);
      chk("ovf.sp_lit", sp, 8'hED);

      prog = '{8'h00, 8'hAA, 8'h02, 8'hFA, 8'h01, 8'h04, 8'h0F};
      load(); run("push_io");
      chk("push_io.tos", ram[8'hEF], 8'h01);
      chk("push_io.fa_ignored", ram[8'hFA], 8'h00);
      chk("push_io.sp_lit", sp, 8'hEE);

      prog = '{8'h00, 8'h0C, 8'h00, 8'h17, 8'h06, 8'h02, 8'hF0, 8'h0F};
      load();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int k = 0; k < 50 && mem_readwriteN; k++) begin
         @(posedge clk); #1;
      end
      chk("rstw.write_seen", 8'(mem_readwriteN), 8'd0);
      reset = 1'b1; #1;
      chk("rstw.rwN_async", 8'(mem_readwriteN), 8'd1);
      chk("rstw.busy", 8'(busy), 8'd0);
      chk("rstw.pc", pc, 8'd0);
      chk("rstw.sp", sp, TOP);
      @(negedge clk); #1;
      chk("rstw.no_write", ram[8'hEF], 8'h00);
      reset = 1'b0;
      run("rerun");
      chk("rerun.mem_f0", ram[8'hF0], 8'h23);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
